iseq_loader: RTL and testbench



---
 rtl/softmc_pkg.sv | 32 +++
 rtl/iseq_loader_if.sv | 49 ++++
 rtl/iseq_loader.sv | 161 ++++++++++++++++
 tb/tb_iseq_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmc_pkg.sv
// Shared constants for the instruction-sequence path: the opcode field, the END
// delimiter, the pad word and the loader state encoding. iseq_dispatcher uses
// the same opcode constants.
package softmc_pkg;

  // Opcode field position inside a 32-bit instruction word
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 29;

  // END delimiter. The loader strips it; it never reaches a FIFO.
  localparam logic [2:0] OPC_END = 3'b111;

  // Pad word for odd-length sequences: a zero-cycle WAIT
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Loader state encoding
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_LOAD       = 3'd1;
  localparam state_t ST_PAD        = 3'd2;
  localparam state_t ST_KICK       = 3'd3;
  localparam state_t ST_WAIT_START = 3'd4;
  localparam state_t ST_WAIT_DONE  = 3'd5;
  localparam state_t ST_DROP       = 3'd6;

  // Extract the opcode field of an instruction word
  function automatic logic [2:0] opcode_of(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/iseq_loader_if.sv
// Bus between iseq_loader and its surroundings. It carries the host word
// handshake, both instruction FIFO write ports and the dispatcher start/busy
// pair. master is the loader side; slave is the host/FIFO/dispatcher side.
interface iseq_loader_if;

  logic        host_valid;
  logic [31:0] host_data;
  logic        host_ready;

  logic        instr0_fifo_wr;
  logic [31:0] instr0_fifo_data;
  logic        instr0_fifo_full;

  logic        instr1_fifo_wr;
  logic [31:0] instr1_fifo_data;
  logic        instr1_fifo_full;

  logic        process_iseq;
  logic        dispatcher_busy;

  modport master (
    input  host_valid,
    input  host_data,
    output host_ready,
    output instr0_fifo_wr,
    output instr0_fifo_data,
    input  instr0_fifo_full,
    output instr1_fifo_wr,
    output instr1_fifo_data,
    input  instr1_fifo_full,
    output process_iseq,
    input  dispatcher_busy
  );

  modport slave (
    output host_valid,
    output host_data,
    input  host_ready,
    input  instr0_fifo_wr,
    input  instr0_fifo_data,
    output instr0_fifo_full,
    input  instr1_fifo_wr,
    input  instr1_fifo_data,
    output instr1_fifo_full,
    input  process_iseq,
    output dispatcher_busy
  );

endinterface

// File: rtl/iseq_loader.sv
// Host-side producer for the two-slot instruction FIFOs. Host words are split
// alternately into slot 0 and slot 1. END is stripped, and an odd-length
// sequence is padded with a NOP. The dispatcher is then started with a
// one-cycle pulse, and the next sequence is held off until the dispatcher has
// gone busy and back to idle.
module iseq_loader
  import softmc_pkg::*;
#(
  parameter int unsigned MAX_SEQ_LEN = 1024,
  parameter int unsigned LEN_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  iseq_loader_if.master        bus,
  output logic                 loader_busy,
  output logic [LEN_WIDTH-1:0] seq_len,
  output logic                 seq_overflow
);

  localparam logic [LEN_WIDTH-1:0] MAX_CNT = LEN_WIDTH'(MAX_SEQ_LEN);

  state_t               state_q, state_d;
  logic                 slot_q, slot_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] seq_len_q, seq_len_d;
  logic                 ovf_q, ovf_d;

  logic                 is_end;
  logic                 target_full;
  logic                 ready;
  logic                 wr0, wr1;
  logic [31:0]          data0, data1;
  logic                 kick;

  assign is_end      = (opcode_of(bus.host_data) == OPC_END);
  assign target_full = slot_q ? bus.instr1_fifo_full : bus.instr0_fifo_full;

  // Next-state, handshake and FIFO write decode. Every output is forced low while rst is high.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    cnt_d     = cnt_q;
    seq_len_d = seq_len_q;
    ovf_d     = ovf_q;
    ready     = 1'b0;
    wr0       = 1'b0;
    wr1       = 1'b0;
    data0     = '0;
    data1     = '0;
    kick      = 1'b0;

    if (!rst) begin
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          // END never needs FIFO space, so only data words look at the target FIFO
          ready = is_end | ~target_full;
          if (bus.host_valid && ready) begin
            if (is_end) begin
              if (cnt_q == '0) begin
                state_d = ST_IDLE;
              end else if (slot_q) begin
                state_d = ST_PAD;
              end else begin
                state_d = ST_KICK;
              end
            end else if (cnt_q == MAX_CNT) begin
              ovf_d   = 1'b1;
              state_d = ST_DROP;
            end else begin
              if (slot_q) begin
                wr1   = 1'b1;
                data1 = bus.host_data;
              end else begin
                wr0   = 1'b1;
                data0 = bus.host_data;
              end
              slot_d  = ~slot_q;
              cnt_d   = cnt_q + 1'b1;
              state_d = ST_LOAD;
            end
          end
        end

        ST_PAD: begin
          if (!bus.instr1_fifo_full) begin
            wr1     = 1'b1;
            data1   = NOP_WORD;
            slot_d  = 1'b0;
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_KICK;
          end
        end

        ST_KICK: begin
          kick      = 1'b1;
          seq_len_d = cnt_q;
          state_d   = ST_WAIT_START;
        end

        ST_WAIT_START: begin
          if (bus.dispatcher_busy) begin
            state_d = ST_WAIT_DONE;
          end
        end

        ST_WAIT_DONE: begin
          if (!bus.dispatcher_busy) begin
            cnt_d   = '0;
            slot_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end

        ST_DROP: begin
          // Overflowed sequence: swallow every word up to and including END, with no writes
          ready = 1'b1;
          if (bus.host_valid && is_end) begin
            cnt_d   = '0;
            slot_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end

        default: begin
          cnt_d   = '0;
          slot_d  = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, write pointer, counters and the sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      slot_q    <= 1'b0;
      cnt_q     <= '0;
      seq_len_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      cnt_q     <= cnt_d;
      seq_len_q <= seq_len_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.host_ready       = ready;
  assign bus.instr0_fifo_wr   = wr0;
  assign bus.instr0_fifo_data = data0;
  assign bus.instr1_fifo_wr   = wr1;
  assign bus.instr1_fifo_data = data1;
  assign bus.process_iseq     = kick;

  assign loader_busy  = ~rst & (state_q != ST_IDLE);
  assign seq_len      = seq_len_q;
  assign seq_overflow = ovf_q;

endmodule

// File: tb/tb_iseq_loader.sv
// Directed bench for iseq_loader (MAX_SEQ_LEN=4). The FIFOs are modelled as
// logging queues. Inputs are driven on the falling edge and outputs are sampled
// just after it.
module tb_iseq_loader;

  localparam logic [31:0] END_W = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        loader_busy;
  logic [15:0] seq_len;
  logic        seq_overflow;

  iseq_loader_if bus ();

  iseq_loader #(.MAX_SEQ_LEN(4), .LEN_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .loader_busy  (loader_busy),
    .seq_len      (seq_len),
    .seq_overflow (seq_overflow)
  );

  always #5 clk = ~clk;

  int vec_cnt     = 0;
  int miscompares = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int cyc       = 0;
  int end_cyc   = 0;
  int pulse_cyc = 0;
  int pulses    = 0;

  int b0, b1, bp;

  // FIFO write log, END acceptance time and start-pulse log
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.instr0_fifo_wr) q0.push_back(bus.instr0_fifo_data);
    if (bus.instr1_fifo_wr) q1.push_back(bus.instr1_fifo_data);
    if (bus.host_valid && bus.host_ready && bus.host_data[31:29] == 3'b111) end_cyc <= cyc;
    if (bus.process_iseq) begin
      pulses    <= pulses + 1;
      pulse_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qat(input int which, input int idx);
    if (which == 0) return (idx < q0.size()) ? q0[idx] : 32'hDEAD_BEEF;
    return (idx < q1.size()) ? q1[idx] : 32'hDEAD_BEEF;
  endfunction

  task automatic snap();
    b0 = q0.size();
    b1 = q1.size();
    bp = pulses;
  endtask

  // Present one word at a falling edge and return at the falling edge after it is taken
  task automatic send(input logic [31:0] w);
    int n;
    bus.host_valid = 1'b1;
    bus.host_data  = w;
    #1;
    n = 0;
    while (!bus.host_ready && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 100) chk("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.host_valid = 1'b0;
    bus.host_data  = '0;
  endtask

  task automatic wait_pulse();
    int n;
    n = 0;
    while (pulses == bp && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pulse_count", 32'(pulses - bp), 32'd1);
  endtask

  task automatic disp_handshake();
    int n;
    bus.dispatcher_busy = 1'b1;
    repeat (3) @(negedge clk);
    bus.dispatcher_busy = 1'b0;
    n = 0;
    while (loader_busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("idle_after_done", 32'(loader_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.host_valid       = 1'b0;
    bus.host_data        = '0;
    bus.instr0_fifo_full = 1'b0;
    bus.instr1_fifo_full = 1'b0;
    bus.dispatcher_busy  = 1'b0;

    // Outputs during reset and reset values afterwards
    @(negedge clk);
    bus.host_valid = 1'b1;
    bus.host_data  = 32'h1234_5678;
    #1;
    chk("rst_ready", 32'(bus.host_ready), 32'd0);
    chk("rst_wr0", 32'(bus.instr0_fifo_wr), 32'd0);
    chk("rst_wr1", 32'(bus.instr1_fifo_wr), 32'd0);
    chk("rst_data0", bus.instr0_fifo_data, 32'd0);
    chk("rst_kick", 32'(bus.process_iseq), 32'd0);
    chk("rst_busy", 32'(loader_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    chk("rst_seq_len", 32'(seq_len), 32'd0);
    chk("rst_ovf", 32'(seq_overflow), 32'd0);
    chk("idle_ready", 32'(bus.host_ready), 32'd1);
    @(negedge clk);

    // Four words, even length: alternate slots, pulse one cycle after END
    snap();
    send(32'h1000_0001); send(32'h2000_0002); send(32'h3000_0003); send(32'h4000_0004);
    send(END_W); idle();
    wait_pulse();
    chk("t1_latency", 32'(pulse_cyc - end_cyc), 32'd1);
    chk("t1_seq_len", 32'(seq_len), 32'd4);
    chk("t1_n0", 32'(q0.size() - b0), 32'd2);
    chk("t1_n1", 32'(q1.size() - b1), 32'd2);
    chk("t1_q0a", qat(0, b0), 32'h1000_0001);
    chk("t1_q0b", qat(0, b0 + 1), 32'h3000_0003);
    chk("t1_q1a", qat(1, b1), 32'h2000_0002);
    chk("t1_q1b", qat(1, b1 + 1), 32'h4000_0004);
    chk("t1_busy", 32'(loader_busy), 32'd1);
    disp_handshake();

    // Three words, odd length: NOP pad into slot 1, pulse two cycles after END
    snap();
    send(32'h0A00_000A); send(32'h0B00_000B); send(32'h0C00_000C);
    send(END_W); idle();
    wait_pulse();
    chk("t2_latency", 32'(pulse_cyc - end_cyc), 32'd2);
    chk("t2_seq_len", 32'(seq_len), 32'd4);
    chk("t2_q0b", qat(0, b0 + 1), 32'h0C00_000C);
    chk("t2_q1a", qat(1, b1), 32'h0B00_000B);
    chk("t2_pad", qat(1, b1 + 1), 32'h0000_0000);
    chk("t2_n1", 32'(q1.size() - b1), 32'd2);
    disp_handshake();

    // END alone: nothing written, no pulse, seq_len kept
    snap();
    send(END_W); idle();
    repeat (3) @(negedge clk);
    chk("t3_pulses", 32'(pulses - bp), 32'd0);
    chk("t3_writes", 32'((q0.size() - b0) + (q1.size() - b1)), 32'd0);
    chk("t3_seq_len", 32'(seq_len), 32'd4);
    chk("t3_busy", 32'(loader_busy), 32'd0);

    // Slot-1 FIFO full for five cycles while slot 1 is targeted
    snap();
    send(32'h5000_0050);
    bus.instr1_fifo_full = 1'b1;
    bus.host_valid = 1'b1;
    bus.host_data  = 32'h5100_0051;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_stall%0d", i), 32'(bus.host_ready), 32'd0);
      @(negedge clk); #1;
    end
    bus.instr1_fifo_full = 1'b0;
    bus.instr0_fifo_full = 1'b1;
    #1;
    chk("t4_release", 32'(bus.host_ready), 32'd1);
    @(negedge clk);
    bus.instr0_fifo_full = 1'b0;
    send(32'h5200_0052); send(32'h5300_0053);
    send(END_W); idle();
    wait_pulse();
    chk("t4_seq_len", 32'(seq_len), 32'd4);
    chk("t4_n0", 32'(q0.size() - b0), 32'd2);
    chk("t4_n1", 32'(q1.size() - b1), 32'd2);
    chk("t4_q1a", qat(1, b1), 32'h5100_0051);
    chk("t4_q1b", qat(1, b1 + 1), 32'h5300_0053);
    chk("t4_q0b", qat(0, b0 + 1), 32'h5200_0052);

    // Next sequence presented while the dispatcher is busy
    bus.dispatcher_busy = 1'b1;
    bus.host_valid = 1'b1;
    bus.host_data  = 32'h6000_0060;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("t5_hold%0d", i), 32'(bus.host_ready), 32'd0);
    end
    bus.dispatcher_busy = 1'b0;
    #1;
    chk("t5_fall_cycle", 32'(bus.host_ready), 32'd0);
    @(negedge clk); #1;
    chk("t5_accept", 32'(bus.host_ready), 32'd1);
    chk("t5_idle", 32'(loader_busy), 32'd0);
    snap();
    @(negedge clk);
    send(32'h6100_0061);
    send(END_W); idle();
    wait_pulse();
    chk("t5_q0", qat(0, b0), 32'h6000_0060);
    chk("t5_q1", qat(1, b1), 32'h6100_0061);
    chk("t5_seq_len", 32'(seq_len), 32'd2);
    disp_handshake();

    // Overflow: six words against a limit of four, then END
    snap();
    send(32'h7000_0001); send(32'h7000_0002); send(32'h7000_0003); send(32'h7000_0004);
    chk("t6_at_limit", 32'(seq_overflow), 32'd0);
    send(32'h7000_0005);
    chk("t6_ovf", 32'(seq_overflow), 32'd1);
    send(32'h7000_0006);
    send(END_W); idle();
    repeat (4) @(negedge clk);
    chk("t6_pulses", 32'(pulses - bp), 32'd0);
    chk("t6_n0", 32'(q0.size() - b0), 32'd2);
    chk("t6_n1", 32'(q1.size() - b1), 32'd2);
    chk("t6_busy", 32'(loader_busy), 32'd0);
    chk("t6_seq_len", 32'(seq_len), 32'd2);
    chk("t6_ovf_sticky", 32'(seq_overflow), 32'd1);

    // Reset in the middle of LOAD
    send(32'h8000_0001); send(32'h8000_0002);
    rst = 1'b1;
    bus.host_data = 32'h8000_0003;
    #1;
    chk("t7_ready", 32'(bus.host_ready), 32'd0);
    chk("t7_wr0", 32'(bus.instr0_fifo_wr), 32'd0);
    chk("t7_busy", 32'(loader_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    chk("t7_seq_len", 32'(seq_len), 32'd0);
    chk("t7_ovf", 32'(seq_overflow), 32'd0);
    chk("t7_idle_ready", 32'(bus.host_ready), 32'd1);
    @(negedge clk);
    snap();
    send(32'h9000_0009);
    send(END_W); idle();
    wait_pulse();
    chk("t7_q0", qat(0, b0), 32'h9000_0009);
    chk("t7_pad", qat(1, b1), 32'h0000_0000);
    chk("t7_seq_len2", 32'(seq_len), 32'd2);
    chk("t7_latency", 32'(pulse_cyc - end_cyc), 32'd2);
    disp_handshake();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
